rom_loader: RTL

Cartridge image loader between the SPI download channel (`ioctl_*`) and the SDRAM controller's write port. It accepts one byte per `ioctl_wr` strobe, forwards it through the SDRAM toggle/ack write handshake, and throttles the downloader with `ioctl_wait`. It also accumulates the address mask used to mirror cartridge reads, and at end of download detects a 512-byte copier header, publishing the read offset that the ROM read path adds.

---
 rtl/rom_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - cartridge image loader: ioctl byte stream to SDRAM toggle/ack write port
// Tracks the address mask and image size, and detects a copier header at end of download.
module rom_loader #(
    parameter int AW        = 22,
    parameter int HDR_BYTES = 512
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          we,
    input  logic          we_ack,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic [AW-1:0] cart_mask,
    output logic [9:0]    rd_offset,
    output logic [AW:0]   rom_size,
    output logic          load_done,
    output logic          overrun
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_FINISH   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_dl_q;
    logic          r_wait;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [7:0]    r_wdata;
    logic [AW-1:0] r_cart_mask;
    logic [9:0]    r_rd_offset;
    logic [AW:0]   r_rom_size;
    logic          r_load_done;
    logic          r_overrun;

    logic          w_dl_rise;
    logic          w_in_range;
    logic          w_accept;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_addr_p1;
    logic [9:0]    w_last_lo;
    logic          w_hdr;

    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_in_range = (ioctl_addr >> AW) == 25'd0;
    assign w_accept   = ioctl_wr & w_in_range;
    assign w_addr     = ioctl_addr[AW-1:0];
    assign w_addr_p1  = {1'b0, w_addr} + {{AW{1'b0}}, 1'b1};
    // Low bits of (rom_size-1) depend only on the low bits of rom_size.
    assign w_last_lo  = r_rom_size[9:0] - 10'd1;
    assign w_hdr      = (r_rom_size != '0) && (w_last_lo == 10'(HDR_BYTES - 1));

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= S_IDLE;
            r_dl_q      <= 1'b0;
            r_wait      <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_cart_mask <= '0;
            r_rd_offset <= '0;
            r_rom_size  <= '0;
            r_load_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_dl_q      <= ioctl_download;
            r_load_done <= 1'b0;
            if (w_dl_rise) begin
                r_cart_mask <= '0;
                r_rom_size  <= '0;
                r_rd_offset <= '0;
                r_overrun   <= 1'b0;
                r_wait      <= 1'b0;
                r_state     <= S_LOAD;
                // A strobe coinciding with the start edge is the first byte of the new image.
                if (w_accept) begin
                    r_waddr     <= w_addr;
                    r_wdata     <= ioctl_dout;
                    r_we        <= ~r_we;
                    r_wait      <= 1'b1;
                    r_cart_mask <= w_addr;
                    r_rom_size  <= w_addr_p1;
                    r_state     <= S_WAIT_ACK;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_LOAD: begin
                        if (!ioctl_download) begin
                            r_state <= S_FINISH;
                        end else if (w_accept) begin
                            r_waddr     <= w_addr;
                            r_wdata     <= ioctl_dout;
                            r_we        <= ~r_we;
                            r_wait      <= 1'b1;
                            r_cart_mask <= r_cart_mask | w_addr;
                            if (w_addr_p1 > r_rom_size) begin
                                r_rom_size <= w_addr_p1;
                            end
                            r_state     <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (ioctl_wr) begin
                            r_overrun <= 1'b1;
                        end
                        if (we_ack == r_we) begin
                            r_wait  <= 1'b0;
                            r_state <= ioctl_download ? S_LOAD : S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        r_rd_offset <= w_hdr ? 10'(HDR_BYTES) : 10'd0;
                        r_load_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign cart_mask  = r_cart_mask;
    assign rd_offset  = r_rd_offset;
    assign rom_size   = r_rom_size;
    assign load_done  = r_load_done;
    assign overrun    = r_overrun;

endmodule
